// File: rtl/uart_cmd_sender.sv
// Two-frame 8N1 UART transmitter for a 16-bit command word: high byte first, then low byte,
// back to back, with a set-and-hold completion flag.
module uart_cmd_sender #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [7:0]    lo_buf;
    logic          tick;
    logic          frame_end;

    assign tick      = (state != IDLE) && (baud_cnt == CW'(BAUD_DIV - 1));
    assign frame_end = tick && (bit_cnt == 4'd9);

    // Shift register resets to all ones so TX goes high the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            lo_buf   <= '0;
            cmd_snt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (snd_cmd) begin
                        lo_buf  <= cmd[7:0];
                        shreg   <= {1'b1, cmd[15:8], 1'b0};
                        cmd_snt <= 1'b0;
                        state   <= HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (tick) baud_cnt <= '0;
                    else      baud_cnt <= baud_cnt + CW'(1);

                    if (frame_end) begin
                        bit_cnt <= '0;
                        if (state == HIGH) begin
                            shreg <= {1'b1, lo_buf, 1'b0};
                            state <= LOW;
                        end else begin
                            shreg   <= '1;
                            cmd_snt <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (tick) begin
                        shreg   <= {1'b1, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign TX   = shreg[0];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Self-checking bench for uart_cmd_sender: table-driven and random sends compared cycle by
// cycle against a waveform model, plus reset, hold and ignored-strobe sequences.
module tb_uart_cmd_sender;

    localparam int B = 8;
    localparam int FRAME = 10 * B;
    localparam int TOTAL = 20 * B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX;
    logic        busy;
    logic        cmd_snt;

    int checks = 0;
    int errors = 0;

    uart_cmd_sender #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd),
        .TX(TX), .busy(busy), .cmd_snt(cmd_snt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        int          ign_at;
        logic [15:0] ign_c;
        int          tail;
    } vec_t;

    vec_t vecs[8];

    // Expected {TX, busy, cmd_snt} t cycles after the accepting edge.
    function automatic logic [2:0] model(input logic [15:0] c, input int t);
        int f, b;
        logic [7:0] by;
        logic tx;
        if (t >= TOTAL) return 3'b101;
        f  = t / FRAME;
        b  = (t % FRAME) / B;
        by = (f == 0) ? c[15:8] : c[7:0];
        if (b == 0)      tx = 1'b0;
        else if (b == 9) tx = 1'b1;
        else             tx = by[b-1];
        return {tx, 1'b1, 1'b0};
    endfunction

    task automatic check3(input string name, input int t, input logic [2:0] exp);
        checks++;
        if ({TX, busy, cmd_snt} !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got tx=%b busy=%b snt=%b exp tx=%b busy=%b snt=%b",
                     name, t, TX, busy, cmd_snt, exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic send_check(input logic [15:0] c, input int ign_at,
                              input logic [15:0] ign_c, input int tail);
        logic txs[TOTAL];
        logic [15:0] word;
        logic framing_ok;
        @(negedge clk);
        snd_cmd = 1'b1;
        cmd     = c;
        for (int t = 0; t < TOTAL + tail; t++) begin
            @(negedge clk);
            snd_cmd = 1'b0;
            cmd     = 16'($urandom);
            check3("wave", t, model(c, t));
            if (t < TOTAL) txs[t] = TX;
            if (t == ign_at - 1) begin
                snd_cmd = 1'b1;
                cmd     = ign_c;
            end
        end
        framing_ok = 1'b1;
        for (int f = 0; f < 2; f++) begin
            if (txs[f*FRAME + B/2] !== 1'b0) framing_ok = 1'b0;
            if (txs[f*FRAME + 9*B + B/2] !== 1'b1) framing_ok = 1'b0;
            for (int i = 0; i < 8; i++)
                word[(1-f)*8 + i] = txs[f*FRAME + (1+i)*B + B/2];
        end
        checks++;
        if (word !== c || !framing_ok) begin
            errors++;
            $display("FAIL decode got %h framing=%b exp %h", word, framing_ok, c);
        end
    endtask

    initial begin
        vecs[0] = '{16'hA55A, 0,     16'h0000, 4};
        vecs[1] = '{16'h00FF, 40,    16'hDEAD, 30};
        vecs[2] = '{16'h5555, 0,     16'h0000, 2};
        vecs[3] = '{16'h1234, 0,     16'h0000, 2};
        vecs[4] = '{16'hFFFF, 0,     16'h0000, 2};
        vecs[5] = '{16'h0000, 0,     16'h0000, 2};
        vecs[6] = '{16'hBEEF, TOTAL, 16'h1111, 25};
        vecs[7] = '{16'h8001, 1,     16'h7E7E, 3};

        repeat (3) @(negedge clk);
        check3("reset", -1, 3'b100);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check3("idle", -1, 3'b100);

        for (int v = 0; v < 8; v++)
            send_check(vecs[v].c, vecs[v].ign_at, vecs[v].ign_c, vecs[v].tail);

        for (int r = 0; r < 4; r++)
            send_check(16'($urandom), int'($urandom_range(1, TOTAL)), 16'($urandom),
                       int'($urandom_range(2, 6)));

        // completion flag holds while idle
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check3("hold", i, 3'b101);
        end

        // reset during the low-byte start bit
        @(negedge clk);
        snd_cmd = 1'b1;
        cmd     = 16'h6699;
        for (int t = 0; t <= 84; t++) begin
            @(negedge clk);
            snd_cmd = 1'b0;
        end
        check3("pre_rst", 84, model(16'h6699, 84));
        #2 rst = 1'b1;
        #1 check3("async_rst", 85, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check3("post_rst", i, 3'b100);
        end
        send_check(16'hC3C3, 0, 16'h0000, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sender.md
# uart_cmd_sender

Transmit-side counterpart of the two-byte UART command receiver. It accepts a 16-bit command word on a single-cycle strobe and serialises it as two 8N1 UART frames on `TX`, high byte first and then low byte, back to back. It contains its own baud generator, shift register and byte-sequencing FSM. It signals completion with a set-and-hold `cmd_snt` flag. It sits at the host/remote end of the link that feeds the robot's command receiver.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per UART bit (50 MHz / 19200). Legal range is ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `snd_cmd`  in  1  single-cycle strobe; request to send `cmd`
- `cmd`  in  16  command word; sampled only on the accepted `snd_cmd` edge
- `TX`  out  1  UART serial output, idle high
- `busy`  out  1  high while either frame is in progress
- `cmd_snt`  out  1  set when the low byte's stop bit completes; held until the next accepted `snd_cmd`

## Operation
- Reset values: `TX`=1, `busy`=0, `cmd_snt`=0. FSM goes to IDLE, counters clear, and the low-byte buffer clears to 0x00.
- Frame format: start bit (0), then 8 data bits LSB first, then stop bit (1). Each bit lasts `BAUD_DIV` cycles, so one frame is 10·`BAUD_DIV` cycles.
- The `TX` output is registered and is driven from bit 0 of a 10-bit shift register `{stop, data[7:0], start}`. The register shifts right with 1 fill on each baud tick.
- Baud counter is `$clog2(BAUD_DIV)` bits. It counts 0..`BAUD_DIV`-1, and a tick occurs at terminal count. The counter is held at 0 in IDLE.
- Bit counter is 4 bits and counts 0..9 ticks per frame. Reaching 10 ends the frame.
- FSM states:
  - IDLE
    - On `snd_cmd`=1: latch `cmd[7:0]` into the low-byte buffer, load the shift register with `cmd[15:8]`, clear `cmd_snt`, set `busy`, and go to HIGH.
  - HIGH
    - At the end of the frame: load the shift register from the low-byte buffer, reset the bit counter, and go to LOW. There is no idle gap between frames.
  - LOW
    - At the end of the frame: set `cmd_snt`, clear `busy`, and go to IDLE.
- `snd_cmd` while `busy`=1 is ignored. Changes on `cmd` while busy have no effect.
- `busy` is 1 exactly in HIGH and LOW.
- `rst` asserted mid-frame: `TX` returns to 1 asynchronously and all state returns to reset values. The partial frame is abandoned and `cmd_snt` stays 0.

## Timing
- Let edge k be the rising edge at which `snd_cmd`=1 is sampled in IDLE.
- After edge k: `TX`=0 (start bit of the high byte) and `busy`=1. `cmd_snt` goes to 0 at the same edge.
- High frame: data bit i is on `TX` from edge k+(1+i)·`BAUD_DIV` for `BAUD_DIV` cycles. The stop bit starts at edge k+9·`BAUD_DIV`.
- Low frame: the start bit begins at edge k+10·`BAUD_DIV`, and the stop bit begins at edge k+19·`BAUD_DIV`.
- After edge k+20·`BAUD_DIV`: `busy`=0, `cmd_snt`=1, and `TX`=1.
- Back-to-back sends: a `snd_cmd` sampled at edge k+20·`BAUD_DIV`+1 or later is accepted. Its start bit follows the previous stop bit with at least one idle cycle.
- `snd_cmd` at edge k+20·`BAUD_DIV` itself is ignored, because `busy` is still 1 when that edge samples it.
- Total latency from strobe to `cmd_snt` is 20·`BAUD_DIV` cycles.

## Test plan
All scenarios use `BAUD_DIV`=8.
- **Basic send.** Apply `snd_cmd` with `cmd`=16'hA55A. `TX` must show frame 0xA5 (bit sequence 0,1,0,1,0,0,1,0,1,1), then frame 0x5A immediately after. `cmd_snt` must rise exactly 160 cycles after the strobe edge and `busy` must fall in the same cycle.
- **Loopback.** Drive `TX` into the team's 2-byte command receiver. Send 16'h1234, then 16'hFFFF, then 16'h0000. The receiver's `cmd` must equal each word, its `cmd_rdy` must pulse once per word, and `cmd_snt` must be observed before each next strobe.
- **Ignored strobes.** Pulse `snd_cmd` with `cmd`=16'hDEAD at cycle 40 of an active 16'h00FF send. The output must still be 0x00 followed by 0xFF, with exactly 160 cycles of `busy`, and no second transmission may follow.
- **`cmd_snt` hold and clear.** After a send completes, wait 100 cycles; `cmd_snt` must stay 1. Issue a new `snd_cmd`; `cmd_snt` must read 0 on the cycle after the strobe.
- **Reset mid-frame.** Assert `rst` at cycle 85 of a send (during the low-byte start). `TX` must be 1 immediately, without waiting for a clock edge. After release: `busy`=0, `cmd_snt`=0, and no further frame bits may appear. A subsequent send of 16'hC3C3 must be transmitted correctly.
- **Bit timing.** Measure every `TX` transition over a 16'h5555 send. All bit periods must be exactly 8 cycles, with no glitches between the high and low frames.
